sm_mips_top: RTL and testbench
==============================

// Module: sm_mips_top
// PURPOSE
//  Top level of a single-cycle 32-bit MIPS-subset microcontroller: clock divider, CPU core,
//  instruction ROM, data RAM and a 16-bit GPIO port. Exposes a debug tap that reads the PC
//  or any GPR. Sits directly under the board/bench wrapper.
// PARAMETERS
//  GPIO_WIDTH  16     width of gpioInput/gpioOutput
//  ROM_WORDS   64     instruction ROM depth (words), loaded by $readmemh("program.hex")
//  RAM_WORDS   64     data RAM depth (words)
//  (sub-instance sm_clk_divider: bypass 0 = divide, 1 = clk follows clkIn; shift 16 = base divide exponent)
// PORTS
//  clkIn       in   1   board clock; the single clock
//  rst_n       in   1   reset, asynchronous, ACTIVE-HIGH (1 = reset) despite the name
//  clkDevide   in   4   divider select: cpu clock = clkIn / 2^(shift+clkDevide+1)
//  clkEnable   in   1   1 = divider counter runs; 0 = cpu clock frozen
//  clk         out  1   derived cpu clock (all core state clocks on its rising edge)
//  regAddr     in   5   debug select: 0 = PC, 1..31 = GPR[regAddr]
//  regData     out  32  debug data, combinational from regAddr
//  gpioInput   in   16  GPIO input pins
//  gpioOutput  out  16  GPIO output register
// BEHAVIOUR
//  - Reset (rst_n=1, async): PC=0, gpioOutput=0, divider counter=0. GPRs and RAM not reset.
//  - Divider: bypass=1 -> clk=clkIn; else 32-bit counter +1 per clkIn when clkEnable,
//    clk = cnt[shift+clkDevide].
//  - PC is a word index; instr = ROM[PC mod ROM_WORDS]; regData for regAddr=0 is PC (byte addr = PC<<2).
//  - Single cycle: every clk rising edge commits one instruction; no stalls, no delay slot.
//  - next PC = PC+1, or PC+1+sext(imm16) for taken beq (rs==rt) / bne (rs!=rt). PC wraps at 2^32.
//  - Supported (all unsigned/modular, no overflow traps):
//    R-type op=0: addu rd=rs+rt; subu rd=rs-rt; or rd=rs|rt; sltu rd=(rs<rt unsigned);
//                 srl rd=rt>>shamt (logical, instr[10:6])
//    addiu rt=rs+sext(imm); lui rt={imm,16'h0}; lw rt=mem[rs+sext(imm)]; sw mem[..]=rt;
//    beq, bne as above. Any other encoding (incl. 0x00000000) = nop; PC+1.
//  - GPR[0] reads 0, writes ignored. Two combinational read ports, one write port at clk edge.
//  - Data map (byte addr, word aligned, low 2 bits ignored):
//    0x0000_0000..0x0000_00FF RAM word addr[7:2]; 0x0000_7F00 read = zero-ext gpioInput;
//    0x0000_7F04 gpioOutput (sw writes low 16 bits, lw reads it back); other addresses read 0,
//    writes dropped. RAM read combinational, write at clk edge.
//  - Reset mid-program: PC returns to 0 asynchronously; GPR/RAM keep contents.
// STRUCTURE
//  - Shared package sm_cpu.vh: opcode constants C_SPEC=000000, C_ADDIU=001001, C_LUI=001111,
//    C_LW=100011, C_SW=101011, C_BEQ=000100, C_BNE=000101; funct F_ADDU=100001, F_OR=100101,
//    F_SRL=000010, F_SLTU=101011, F_SUBU=100011, F_ANY=??????.
//    sm_config.vh: SM_GPIO_WIDTH=16.
//  - Instance names fixed for hierarchical bench access: sm_clk_divider (param bypass),
//    sm_cpu (wire instr[31:0]) containing register file instance rf with array rf[0:31].
//  - Natural sub-module: sm_clk_divider; CPU decode/ALU/regfile may live in sm_cpu.
// TESTING (bypass=1, clkDevide=0, clkEnable=1, gpioInput=16'h0A, GPRs pre-zeroed)
//  - Reset held 4 clocks -> PC=0 on regData (regAddr=0) during reset; first release edge -> PC=1.
//  - addiu $2,$0,5; addiu $3,$0,3; addu $2,$2,$3; subu $4,$2,$3 -> rf[2]=8, rf[4]=5.
//  - lui $5,0x1234; srl $6,$5,4; or $7,$5,$6; sltu $8,$6,$5 -> rf[5]=0x12340000,
//    rf[6]=0x01234000, rf[7]=0x13374000, rf[8]=1.
//  - sw $2,8($0); lw $9,8($0) -> rf[9]=8; lw $10,0x7F00($0) -> rf[10]=10;
//    sw $10,0x7F04($0) -> gpioOutput=16'h000A.
//  - addiu $2,$2,1; bne $2,$11,-2 with rf[11]=3 from rf[2]=0 -> loops; PC sequence 0,1,0,1,0,1,2; beq $0,$0,-1 -> PC holds.
//  - Divider: bypass=0, shift=0, clkDevide=1 -> clk period 4 clkIn; clkEnable=0 -> clk frozen.

Source files
------------

// File: rtl/sm_mips_pkg.sv
// sm_mips_pkg
//   Shared definitions for the MIPS-subset microcontroller: opcode and funct
//   encodings, memory-mapped GPIO addresses, the instruction field layout,
//   ALU operation codes and the immediate sign-extension helper.
package sm_mips_pkg;

    localparam logic [5:0] C_SPEC  = 6'b000000;
    localparam logic [5:0] C_ADDIU = 6'b001001;
    localparam logic [5:0] C_LUI   = 6'b001111;
    localparam logic [5:0] C_LW    = 6'b100011;
    localparam logic [5:0] C_SW    = 6'b101011;
    localparam logic [5:0] C_BEQ   = 6'b000100;
    localparam logic [5:0] C_BNE   = 6'b000101;

    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_SUBU  = 6'b100011;

    localparam logic [31:0] GPIO_IN_ADDR  = 32'h0000_7F00;
    localparam logic [31:0] GPIO_OUT_ADDR = 32'h0000_7F04;

    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_t;

    typedef enum logic [2:0] {
        ALU_NONE,
        ALU_ADD,
        ALU_SUB,
        ALU_OR,
        ALU_SLTU,
        ALU_SRL,
        ALU_LUI
    } alu_op_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/sm_mips_if.sv
// sm_mips_if
//   Debug tap and GPIO pins of the microcontroller.
//   regAddr    debug select: 0 = PC, 1..31 = GPR
//   regData    debug read data (combinational from regAddr)
//   gpioInput  GPIO input pins
//   gpioOutput GPIO output register
//   master = board/bench side, slave = microcontroller side.
interface sm_mips_if #(
    parameter int GPIO_WIDTH = 16
);
    logic [4:0]            regAddr;
    logic [31:0]           regData;
    logic [GPIO_WIDTH-1:0] gpioInput;
    logic [GPIO_WIDTH-1:0] gpioOutput;

    modport master (output regAddr, output gpioInput, input regData, input gpioOutput);
    modport slave  (input regAddr, input gpioInput, output regData, output gpioOutput);
endinterface

// File: rtl/sm_mips_clk_divider.sv
// sm_mips_clk_divider
//   Derives the CPU clock from the board clock.
//   clkIn      board clock
//   rst_n      asynchronous reset, active high
//   clkDevide  extra divide exponent added to shift
//   clkEnable  1 = counter runs, 0 = derived clock frozen
//   clk        derived clock: clkIn when bypass, else cnt[shift+clkDevide]
module sm_mips_clk_divider #(
    parameter bit bypass = 1'b0,
    parameter int shift  = 16
) (
    input  logic       clkIn,
    input  logic       rst_n,
    input  logic [3:0] clkDevide,
    input  logic       clkEnable,
    output logic       clk
);
    logic [31:0] cnt;
    logic [4:0]  sel;

    always_ff @(posedge clkIn or posedge rst_n) begin
        if (rst_n)
            cnt <= '0;
        else if (clkEnable)
            cnt <= cnt + 32'd1;
    end

    // Tap index wraps modulo 32 if shift+clkDevide exceeds the counter width.
    assign sel = 5'(shift) + 5'(clkDevide);
    assign clk = bypass ? clkIn : cnt[sel];
endmodule

// File: rtl/sm_mips_cpu.sv
// sm_mips_rf
//   32 x 32 register file, GPR[0] hardwired to zero.
//   ra1/ra2 operand read ports, ra3 debug read port (all combinational),
//   we/wa/wd single write port on the rising clk edge.
module sm_mips_rf (
    input  logic        clk,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  ra3,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] rd3
);
    logic [31:0] rf [0:31];

    always_ff @(posedge clk) begin
        if (we && wa != 5'd0)
            rf[wa] <= wd;
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : rf[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : rf[ra2];
    assign rd3 = (ra3 == 5'd0) ? '0 : rf[ra3];
endmodule

// sm_mips_cpu
//   Single-cycle MIPS-subset core with instruction ROM, data RAM and GPIO.
//   clk/rst_n        cpu clock, asynchronous active-high reset (PC, gpioOutput)
//   regAddr/regData  debug tap: 0 = PC (word index), else GPR
//   gpioInput        read at 0x7F00; gpioOutput written/read at 0x7F04
//   ROM_IMAGE        program, word i at bits [32*i +: 32]
module sm_mips_cpu
    import sm_mips_pkg::*;
#(
    parameter int GPIO_WIDTH = 16,
    parameter int ROM_WORDS  = 64,
    parameter int RAM_WORDS  = 64,
    parameter logic [ROM_WORDS*32-1:0] ROM_IMAGE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            regAddr,
    output logic [31:0]           regData,
    input  logic [GPIO_WIDTH-1:0] gpioInput,
    output logic [GPIO_WIDTH-1:0] gpioOutput
);
    localparam int ROM_AW = $clog2(ROM_WORDS);
    localparam int RAM_AW = $clog2(RAM_WORDS);

    logic [31:0] pc, pc_next, instr, imm_sext;
    logic [31:0] rs_val, rt_val, dbg_val, alu_b, alu_y, wr_data;
    logic [31:0] mem_addr, load_data;
    logic [ROM_AW-1:0] rom_idx;
    logic [RAM_AW-1:0] ram_idx;
    logic [4:0]  rf_wa;
    logic        rf_we, mem_we, use_imm, is_load, take_branch;
    logic        is_ram, is_gin, is_gout, unused_addr_bits;
    instr_t      d;
    alu_op_e     alu_op;
    logic [31:0] ram [RAM_WORDS];

    // ROM depth is a power of two, so the low PC bits give PC mod ROM_WORDS.
    assign rom_idx  = pc[ROM_AW-1:0];
    assign instr    = ROM_IMAGE[32*rom_idx +: 32];
    assign d        = instr;
    assign imm_sext = sext16(instr[15:0]);

    sm_mips_rf rf (
        .clk (clk),
        .ra1 (d.rs),
        .ra2 (d.rt),
        .ra3 (regAddr),
        .we  (rf_we),
        .wa  (rf_wa),
        .wd  (wr_data),
        .rd1 (rs_val),
        .rd2 (rt_val),
        .rd3 (dbg_val)
    );

    always_comb begin
        rf_we       = 1'b0;
        rf_wa       = d.rt;
        alu_op      = ALU_NONE;
        use_imm     = 1'b0;
        is_load     = 1'b0;
        mem_we      = 1'b0;
        take_branch = 1'b0;
        case (d.op)
            C_SPEC: begin
                rf_wa = d.rd;
                case (d.funct)
                    F_ADDU:  begin rf_we = 1'b1; alu_op = ALU_ADD;  end
                    F_SUBU:  begin rf_we = 1'b1; alu_op = ALU_SUB;  end
                    F_OR:    begin rf_we = 1'b1; alu_op = ALU_OR;   end
                    F_SLTU:  begin rf_we = 1'b1; alu_op = ALU_SLTU; end
                    F_SRL:   begin rf_we = 1'b1; alu_op = ALU_SRL;  end
                    default: ;
                endcase
            end
            C_ADDIU: begin rf_we = 1'b1; alu_op = ALU_ADD; use_imm = 1'b1; end
            C_LUI:   begin rf_we = 1'b1; alu_op = ALU_LUI; end
            C_LW:    begin rf_we = 1'b1; is_load = 1'b1; end
            C_SW:    mem_we = 1'b1;
            C_BEQ:   take_branch = (rs_val == rt_val);
            C_BNE:   take_branch = (rs_val != rt_val);
            default: ;
        endcase
    end

    assign alu_b = use_imm ? imm_sext : rt_val;

    always_comb begin
        alu_y = '0;
        case (alu_op)
            ALU_ADD:  alu_y = rs_val + alu_b;
            ALU_SUB:  alu_y = rs_val - alu_b;
            ALU_OR:   alu_y = rs_val | alu_b;
            ALU_SLTU: alu_y = {31'd0, rs_val < alu_b};
            ALU_SRL:  alu_y = rt_val >> d.shamt;
            ALU_LUI:  alu_y = {instr[15:0], 16'h0000};
            default:  alu_y = '0;
        endcase
    end

    // Data map decode; byte offset within the word is ignored.
    assign mem_addr         = rs_val + imm_sext;
    assign unused_addr_bits = ^mem_addr[1:0];
    assign is_ram           = (mem_addr >> (RAM_AW + 2)) == 32'd0;
    assign is_gin           = mem_addr[31:2] == GPIO_IN_ADDR[31:2];
    assign is_gout          = mem_addr[31:2] == GPIO_OUT_ADDR[31:2];
    assign ram_idx          = mem_addr[RAM_AW+1:2];

    always_comb begin
        load_data = '0;
        if (is_ram)
            load_data = ram[ram_idx];
        else if (is_gin)
            load_data = 32'(gpioInput);
        else if (is_gout)
            load_data = 32'(gpioOutput);
    end

    assign wr_data = is_load ? load_data : alu_y;
    assign pc_next = take_branch ? pc + 32'd1 + imm_sext : pc + 32'd1;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            pc <= '0;
        else
            pc <= pc_next;
    end

    always_ff @(posedge clk) begin
        if (mem_we && is_ram)
            ram[ram_idx] <= rt_val;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            gpioOutput <= '0;
        else if (mem_we && is_gout)
            gpioOutput <= rt_val[GPIO_WIDTH-1:0];
    end

    assign regData = (regAddr == 5'd0) ? pc : dbg_val;
endmodule

// File: rtl/sm_mips_top.sv
// sm_mips_top
//   MIPS-subset microcontroller top: clock divider plus single-cycle core.
//   clkIn      board clock
//   rst_n      asynchronous reset, ACTIVE HIGH despite the name
//   clkDevide  cpu clock = clkIn / 2^(DIV_SHIFT+clkDevide+1) unless bypassed
//   clkEnable  divider counter enable
//   clk        derived cpu clock
//   bus        debug tap and GPIO (sm_mips_if.slave)
//   ROM_IMAGE  program contents, word i at bits [32*i +: 32]
module sm_mips_top #(
    parameter int GPIO_WIDTH = 16,
    parameter int ROM_WORDS  = 64,
    parameter int RAM_WORDS  = 64,
    parameter bit DIV_BYPASS = 1'b0,
    parameter int DIV_SHIFT  = 16,
    parameter logic [ROM_WORDS*32-1:0] ROM_IMAGE = '0
) (
    input  logic       clkIn,
    input  logic       rst_n,
    input  logic [3:0] clkDevide,
    input  logic       clkEnable,
    output logic       clk,
    sm_mips_if.slave   bus
);
    sm_mips_clk_divider #(
        .bypass (DIV_BYPASS),
        .shift  (DIV_SHIFT)
    ) sm_clk_divider (
        .clkIn     (clkIn),
        .rst_n     (rst_n),
        .clkDevide (clkDevide),
        .clkEnable (clkEnable),
        .clk       (clk)
    );

    sm_mips_cpu #(
        .GPIO_WIDTH (GPIO_WIDTH),
        .ROM_WORDS  (ROM_WORDS),
        .RAM_WORDS  (RAM_WORDS),
        .ROM_IMAGE  (ROM_IMAGE)
    ) sm_cpu (
        .clk        (clk),
        .rst_n      (rst_n),
        .regAddr    (bus.regAddr),
        .regData    (bus.regData),
        .gpioInput  (bus.gpioInput),
        .gpioOutput (bus.gpioOutput)
    );
endmodule

// File: tb/tb_sm_mips_top.sv
module tb_sm_mips_top;

    logic       clk_in = 1'b0;
    logic       rst, rst2;
    logic [3:0] div1, div2;
    logic       en1, en2;
    logic       clk1, clk2;

    sm_mips_if #(.GPIO_WIDTH(16)) bus1 ();
    sm_mips_if #(.GPIO_WIDTH(16)) bus2 ();

    localparam logic [64*32-1:0] PROG = {
        {47{32'h0000_0000}},
        32'h1000FFFF,   // 16 beq $0,$0,-1
        32'h144BFFFE,   // 15 bne $2,$11,-2
        32'h24420001,   // 14 addiu $2,$2,1
        32'h240B0003,   // 13 addiu $11,$0,3
        32'h24020000,   // 12 addiu $2,$0,0
        32'hAC0A7F04,   // 11 sw $10,0x7F04($0)
        32'h8C0A7F00,   // 10 lw $10,0x7F00($0)
        32'h8C090008,   //  9 lw $9,8($0)
        32'hAC020008,   //  8 sw $2,8($0)
        32'h00C5402B,   //  7 sltu $8,$6,$5
        32'h00A63825,   //  6 or $7,$5,$6
        32'h00053102,   //  5 srl $6,$5,4
        32'h3C051234,   //  4 lui $5,0x1234
        32'h00432023,   //  3 subu $4,$2,$3
        32'h00431021,   //  2 addu $2,$2,$3
        32'h24030003,   //  1 addiu $3,$0,3
        32'h24020005    //  0 addiu $2,$0,5
    };

    sm_mips_top #(
        .GPIO_WIDTH (16), .ROM_WORDS (64), .RAM_WORDS (64),
        .DIV_BYPASS (1'b1), .DIV_SHIFT (16), .ROM_IMAGE (PROG)
    ) u_dut (
        .clkIn (clk_in), .rst_n (rst), .clkDevide (div1),
        .clkEnable (en1), .clk (clk1), .bus (bus1)
    );

    sm_mips_top #(
        .GPIO_WIDTH (16), .ROM_WORDS (64), .RAM_WORDS (64),
        .DIV_BYPASS (1'b0), .DIV_SHIFT (0)
    ) u_div (
        .clkIn (clk_in), .rst_n (rst2), .clkDevide (div2),
        .clkEnable (en2), .clk (clk2), .bus (bus2)
    );

    always #10 clk_in = ~clk_in;

    typedef struct {
        int          cyc;
        int          addr;   // 0..31 debug tap, 32 = gpioOutput
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   div_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int c, input int a, input logic [31:0] v, input string n);
        exp_t e;
        e.cyc = c; e.addr = a; e.val = v; e.name = n;
        sb.push_back(e);
    endtask

    // Committed-instruction counter: one per cpu clock edge out of reset.
    always @(posedge clk1) if (!rst) cyc++;

    exp_t        cur;
    logic [31:0] act;
    always @(negedge clk1) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            if (cur.addr == 32) begin
                act = 32'(bus1.gpioOutput);
            end else begin
                bus1.regAddr = 5'(cur.addr);
                #1;
                act = bus1.regData;
            end
            if (cur.cyc != cyc)
                check({cur.name, "_late"}, 32'(cyc), 32'(cur.cyc));
            else
                check(cur.name, act, cur.val);
        end
    end

    longint last_rise = -1;
    int     rises = 0;
    int     per, e_per;
    always @(posedge clk2) begin
        rises++;
        if (last_rise >= 0 && div_q.size() != 0) begin
            per   = int'(($time - last_rise) / 20);
            e_per = div_q.pop_front();
            check("div_period", 32'(per), 32'(e_per));
        end
        last_rise = $time;
    end

    int   r0;
    logic lvl;
    initial begin
        rst = 1'b0; rst2 = 1'b0;
        en1 = 1'b1; en2 = 1'b1;
        div1 = 4'd0; div2 = 4'd1;
        bus1.gpioInput = 16'h000A;
        bus2.gpioInput = 16'h0000;
        bus2.regAddr   = 5'd0;

        push(0,  0,  32'd0,        "rst_pc");
        push(0,  32, 32'd0,        "rst_gpio");
        push(1,  0,  32'd1,        "pc_first");
        push(1,  2,  32'd5,        "addiu_r2");
        push(2,  3,  32'd3,        "addiu_r3");
        push(3,  2,  32'd8,        "addu_r2");
        push(4,  4,  32'd5,        "subu_r4");
        push(5,  5,  32'h12340000, "lui_r5");
        push(6,  6,  32'h01234000, "srl_r6");
        push(7,  7,  32'h13374000, "or_r7");
        push(8,  8,  32'd1,        "sltu_r8");
        push(10, 9,  32'd8,        "lw_ram_r9");
        push(11, 10, 32'd10,       "lw_gpio_r10");
        push(12, 32, 32'h0000000A, "sw_gpio_out");
        push(12, 0,  32'd12,       "pc_12");
        push(13, 0,  32'd13,       "pc_13");
        push(14, 0,  32'd14,       "pc_14");
        push(14, 11, 32'd3,        "r11");
        push(15, 0,  32'd15,       "pc_15a");
        push(15, 2,  32'd1,        "loop_r2_1");
        push(16, 0,  32'd14,       "bne_taken1");
        push(17, 0,  32'd15,       "pc_15b");
        push(17, 2,  32'd2,        "loop_r2_2");
        push(18, 0,  32'd14,       "bne_taken2");
        push(19, 0,  32'd15,       "pc_15c");
        push(19, 2,  32'd3,        "loop_r2_3");
        push(20, 0,  32'd16,       "bne_fall");
        push(21, 0,  32'd16,       "beq_hold1");
        push(22, 0,  32'd16,       "beq_hold2");

        #1 rst = 1'b1; rst2 = 1'b1;
        repeat (4) @(posedge clk_in);
        #1 check("div_rst_clk", 32'(clk2), 32'd0);
        @(negedge clk_in);
        rst = 1'b0; rst2 = 1'b0;

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk_in);
        check("drain_prog", 32'(sb.size()), 32'd0);

        // Reset between edges: only an asynchronous reset clears PC before the next edge.
        @(posedge clk_in);
        #3 rst = 1'b1;
        push(cyc, 0,  32'd0, "mid_rst_pc");
        push(cyc, 32, 32'd0, "mid_rst_gpio");
        push(cyc, 9,  32'd8, "mid_rst_keep_r9");
        @(negedge clk_in);
        @(negedge clk_in);
        push(cyc + 1, 0, 32'd1, "rel_pc");
        push(cyc + 1, 2, 32'd5, "rel_r2");
        rst = 1'b0;
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk_in);
        check("drain_rst", 32'(sb.size()), 32'd0);

        div_q.push_back(4);
        div_q.push_back(4);
        div_q.push_back(4);
        for (int i = 0; i < 100 && div_q.size() != 0; i++) @(posedge clk_in);
        check("drain_div", 32'(div_q.size()), 32'd0);

        @(negedge clk_in);
        en2 = 1'b0;
        r0  = rises;
        lvl = clk2;
        repeat (20) @(posedge clk_in);
        #1;
        check("div_frozen_rises", 32'(rises), 32'(r0));
        check("div_frozen_level", 32'(clk2), 32'(lvl));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
